// File: rtl/register_file.sv
// rtl/register_file.sv - multi-port register file with PC and power-up clear sweep; optional REGFILE_BYPASS_EN write-to-read forwarding
module register_file #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter int              NRD      = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD*$clog2(NREG)-1:0] rs_select,
    output logic [NRD*XLEN-1:0]       rs,
    input  logic [$clog2(NREG)-1:0]   rd_select,
    input  logic [XLEN-1:0]           rd,
    input  logic [XLEN/8-1:0]         rd_bmask,
    input  logic                      write_enable,
    input  logic [XLEN-1:0]           next_pc,
    input  logic                      pc_enable,
    output logic [XLEN-1:0]           pc,
    output logic                      ready
);

    localparam int AW = $clog2(NREG);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] regs [NREG];
    logic            wr_ok;
    logic [AW-1:0]   rd_sel;

    // Select 0 is hardwired zero; selects past NREG-1 address nothing.
    function automatic logic in_range(input logic [AW-1:0] s);
        return (s != '0) && (32'(s) < 32'(NREG));
    endfunction

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_v,
                                              input logic [XLEN-1:0] new_v,
                                              input logic [XLEN/8-1:0] mask);
        logic [XLEN-1:0] v;
        v = old_v;
        for (int b = 0; b < XLEN/8; b++) begin
            if (mask[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    assign ready = (state == RUN);
    assign wr_ok = (state == RUN) && write_enable && in_range(rd_select);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= '0;
        end else if (state == INIT) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(NREG - 1)) state <= RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (state == RUN && pc_enable) begin
            pc <= next_pc;
        end
    end

    // Storage has no reset; the INIT sweep is the only way contents get cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[clr_idx] <= '0;
            end else if (wr_ok) begin
                regs[rd_select] <= merge(regs[rd_select], rd, rd_bmask);
            end
        end
    end

    always_comb begin
        rs     = '0;
        rd_sel = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_sel = rs_select[k*AW +: AW];
            if (state == RUN && in_range(rd_sel)) begin
                rs[k*XLEN +: XLEN] = regs[rd_sel];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && rd_sel == rd_select) begin
                    rs[k*XLEN +: XLEN] = merge(regs[rd_sel], rd, rd_bmask);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized and directed bench for register_file against a behavioural model
module tb_register_file;

    localparam int              XLEN   = 32;
    localparam int              NREG   = 24;
    localparam int              NRD    = 4;
    localparam int              AW     = $clog2(NREG);
    localparam logic [XLEN-1:0] RST_PC = 32'h0000_0080;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NRD*AW-1:0]     rs_select = '0;
    logic [NRD*XLEN-1:0]   rs;
    logic [AW-1:0]         rd_select = '0;
    logic [XLEN-1:0]       rd = '0;
    logic [XLEN/8-1:0]     rd_bmask = '0;
    logic                  write_enable = 1'b0;
    logic [XLEN-1:0]       next_pc = '0;
    logic                  pc_enable = 1'b0;
    logic [XLEN-1:0]       pc;
    logic                  ready;

    register_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .rs_select(rs_select), .rs(rs),
        .rd_select(rd_select), .rd(rd), .rd_bmask(rd_bmask),
        .write_enable(write_enable), .next_pc(next_pc), .pc_enable(pc_enable),
        .pc(pc), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register array, PC, and a count of INIT cycles done.
    logic [XLEN-1:0] m_regs [NREG];
    logic [XLEN-1:0] m_pc   = RST_PC;
    logic            m_run  = 1'b0;
    int              m_init = 0;

    // One-shot extra check on port 0 at the next read sample.
    logic            x_en  = 1'b0;
    string           x_tag = "";
    logic [XLEN-1:0] x_exp = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] o, input logic [XLEN-1:0] n,
                                                   input logic [XLEN/8-1:0] m);
        logic [XLEN-1:0] r;
        r = 0;
        for (int b = 0; b < XLEN/8; b++) begin
            r = r | ((m[b] ? (n >> (8*b)) & 32'hFF : (o >> (8*b)) & 32'hFF) << (8*b));
        end
        return r;
    endfunction

    function automatic bit write_counts();
        return m_run && write_enable && rd_select != 0 && int'(rd_select) < NREG;
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input int sel);
        logic [XLEN-1:0] v;
        if (!m_run || sel == 0 || sel >= NREG) return 0;
        v = m_regs[sel];
`ifdef REGFILE_BYPASS_EN
        if (write_counts() && sel == int'(rd_select)) v = lane_merge(v, rd, rd_bmask);
`endif
        return v;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_run  = 1'b0;
            m_init = 0;
            m_pc   = RST_PC;
        end else if (!m_run) begin
            m_regs[m_init] = 0;
            m_init++;
            if (m_init == NREG) m_run = 1'b1;
        end else begin
            if (write_counts()) m_regs[rd_select] = lane_merge(m_regs[rd_select], rd, rd_bmask);
            if (pc_enable) m_pc = next_pc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rs%0d", k), rs[k*XLEN +: XLEN], exp_read(int'(rs_select[k*AW +: AW])));
        end
        if (x_en) begin
            check(x_tag, rs[XLEN-1:0], x_exp);
            x_en = 1'b0;
        end
        @(posedge clk);
        model_edge();
        #1;
        check("pc", pc, m_pc);
        check("ready", ready, m_run);
    endtask

    task automatic set_sel(input int s0, input int s1, input int s2, input int s3);
        rs_select = {AW'(s3), AW'(s2), AW'(s1), AW'(s0)};
    endtask

    task automatic wr(input int sel, input logic [XLEN-1:0] d, input logic [XLEN/8-1:0] m);
        rd_select = AW'(sel); rd = d; rd_bmask = m; write_enable = 1'b1;
        cycle();
        write_enable = 1'b0;
    endtask

    task automatic expect_port0(input string tag, input logic [XLEN-1:0] v);
        x_en = 1'b1; x_tag = tag; x_exp = v;
    endtask

    // Counts cycles from rst deassertion until ready, bounded.
    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            cycle();
            n++;
        end
        check(tag, n, NREG);
    endtask

    initial begin
        // Reset, with pc loads and writes held during INIT to show they are ignored.
        rst = 1'b1;
        cycle();
        check("reset_pc", pc, RST_PC);
        check("reset_ready", ready, 1'b0);
        rst = 1'b0;
        pc_enable = 1'b1; next_pc = 32'hDEAD_0000;
        write_enable = 1'b1; rd_select = 5'd3; rd = 32'hFFFF_FFFF; rd_bmask = 4'hF;
        set_sel(0, 3, 5, 23);
        count_init("init_len");
        check("pc_init_hold", pc, RST_PC);
        pc_enable = 1'b0; write_enable = 1'b0;

        // Byte-masked writes.
        wr(5, 32'hAABB_CCDD, 4'hF);
        wr(5, 32'h1122_3344, 4'h2);
        set_sel(5, 5, 0, 3);
        expect_port0("x5_merge", 32'hAABB_33DD);
        cycle();
        wr(5, 32'h5555_5555, 4'h0);
        expect_port0("mask0_nochange", 32'hAABB_33DD);
        cycle();

        // x0 and out-of-range destinations.
        wr(0, 32'hFFFF_FFFF, 4'hF);
        set_sel(0, 5, 30, 31);
        expect_port0("x0_zero", 32'h0);
        cycle();
        wr(30, 32'h1234_5678, 4'hF);
        set_sel(30, 1, 2, 3);
        expect_port0("sel30_zero", 32'h0);
        cycle();
        for (int i = 0; i < NREG; i += 4) begin
            set_sel(i, i + 1, i + 2, i + 3);
            cycle();
        end

        // Same-cycle write and read of x7.
        wr(7, 32'h1, 4'hF);
        set_sel(7, 7, 7, 7);
        rd_select = 5'd7; rd = 32'h2; rd_bmask = 4'hF; write_enable = 1'b1;
`ifdef REGFILE_BYPASS_EN
        expect_port0("x7_same_cycle", 32'h2);
`else
        expect_port0("x7_same_cycle", 32'h1);
`endif
        cycle();
        write_enable = 1'b0;
        expect_port0("x7_after", 32'h2);
        cycle();

        // PC load.
        pc_enable = 1'b1; next_pc = 32'h100;
        cycle();
        pc_enable = 1'b0;
        check("pc_load", pc, 32'h100);
        cycle();
        check("pc_hold", pc, 32'h100);

        // Distinct values everywhere, then concurrent and duplicate selects.
        for (int i = 1; i < NREG; i++) wr(i, 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF);
        set_sel(3, 3, 9, 23);
        expect_port0("dup_sel", 32'h1303_0303);
        cycle();
        set_sel(23, 1, 23, 12);
        cycle();

        // Reset in RUN discards the same-cycle write and PC load.
        rst = 1'b1; write_enable = 1'b1; rd_select = 5'd4; rd = 32'hCAFE_F00D; rd_bmask = 4'hF;
        pc_enable = 1'b1; next_pc = 32'h555;
        cycle();
        check("rst_run_pc", pc, RST_PC);
        rst = 1'b0; write_enable = 1'b0; pc_enable = 1'b0;
        count_init("init_len_after_run_rst");

        // Reset at INIT cycle 10 restarts the sweep.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        count_init("init_len_mid_rst");

        // Random traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            rs_select    = AW'($urandom_range(0, 31)) | (NRD*AW)'($urandom) << AW;
            rd_select    = AW'($urandom_range(0, 31));
            rd           = $urandom;
            rd_bmask     = 4'($urandom);
            write_enable = 1'($urandom);
            pc_enable    = 1'($urandom);
            next_pc      = $urandom;
            rst          = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
